// File: rtl/gol_gen_ctrl.sv
// Generation sequencer for the Game-of-Life array: sweeps row loads, then
// issues single-cycle step enables aligned to the rising edge of vblank.
module gol_gen_ctrl #(
  parameter int ROWS  = 32,
  parameter int ROW_W = 5,
  parameter int GEN_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_load,
  input  logic             cmd_run,
  input  logic             cmd_pause,
  input  logic             cmd_step,
  input  logic [3:0]       rate,
  input  logic             vblank,
  output logic             load_en,
  output logic [ROW_W-1:0] load_row,
  output logic             step_en,
  output logic             running,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAUSED,
    S_STEP_WAIT,
    S_RUN
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state_q;
  logic             vblank_q;
  logic [3:0]       frame_cnt_q;
  logic             load_en_q;
  logic [ROW_W-1:0] load_row_q;
  logic             step_en_q;
  logic             running_q;
  logic             busy_q;
  logic [GEN_W-1:0] gen_count_q;
  logic             vb_rise;

  assign vb_rise   = vblank & ~vblank_q;
  assign load_en   = load_en_q;
  assign load_row  = load_row_q;
  assign step_en   = step_en_q;
  assign running   = running_q;
  assign busy      = busy_q;
  assign gen_count = gen_count_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vblank_q    <= 1'b0;
      frame_cnt_q <= 4'd0;
      load_en_q   <= 1'b0;
      load_row_q  <= '0;
      step_en_q   <= 1'b0;
      running_q   <= 1'b0;
      busy_q      <= 1'b0;
      gen_count_q <= '0;
    end else begin
      vblank_q  <= vblank;
      step_en_q <= 1'b0;
      // Load has top priority in every state, including a restart mid-sweep.
      if (cmd_load) begin
        state_q     <= S_LOAD;
        load_en_q   <= 1'b1;
        load_row_q  <= '0;
        busy_q      <= 1'b1;
        running_q   <= 1'b0;
        gen_count_q <= '0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_row_q == LAST_ROW) begin
              state_q    <= S_PAUSED;
              load_en_q  <= 1'b0;
              load_row_q <= '0;
              busy_q     <= 1'b0;
            end else begin
              load_row_q <= load_row_q + ROW_W'(1);
            end
          end
          S_PAUSED: begin
            if (!cmd_pause) begin
              if (cmd_step) begin
                state_q <= S_STEP_WAIT;
              end else if (cmd_run) begin
                state_q     <= S_RUN;
                running_q   <= 1'b1;
                frame_cnt_q <= 4'd0;
              end
            end
          end
          S_STEP_WAIT: begin
            if (cmd_pause) begin
              state_q <= S_PAUSED;
            end else if (vb_rise) begin
              state_q     <= S_PAUSED;
              step_en_q   <= 1'b1;
              gen_count_q <= gen_count_q + GEN_W'(1);
            end
          end
          S_RUN: begin
            if (cmd_pause) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else if (vb_rise) begin
              // >= so that lowering rate below the running count steps at once.
              if (frame_cnt_q >= rate) begin
                step_en_q   <= 1'b1;
                gen_count_q <= gen_count_q + GEN_W'(1);
                frame_cnt_q <= 4'd0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 4'd1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
